// File: rtl/rv32_arb_pkg.sv
// Shared types for the rv32 instruction/data bus arbiter.
package rv32_arb_pkg;

    // Arbiter FSM: idle, or owning the bus on behalf of one port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Which port wins the bus.
    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/rv32_arb_select.sv
// Combinational grant pick between the fetch and data ports.
// RV32_ARB_ROUND_ROBIN_EN: when defined, a tie goes to the port opposite last_grant;
// otherwise data always wins because the mem-stage instruction is older.
module rv32_arb_select
    import rv32_arb_pkg::*;
(
    input  logic       instr_req,
    input  logic       data_req,
`ifdef RV32_ARB_ROUND_ROBIN_EN
    input  arb_grant_t last_grant,
`endif
    output logic       grant_valid,
    output arb_grant_t grant
);

    // Pick a winner from the two request bits.
    always_comb begin
        grant_valid = instr_req | data_req;
        grant       = GRANT_DATA;
`ifdef RV32_ARB_ROUND_ROBIN_EN
        if (instr_req && data_req) begin
            grant = (last_grant == GRANT_DATA) ? GRANT_INSTR : GRANT_DATA;
        end else if (instr_req) begin
            grant = GRANT_INSTR;
        end
`else
        if (instr_req && !data_req) begin
            grant = GRANT_INSTR;
        end
`endif
    end

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Shares one external memory bus between rv32 fetch and mem-stage ports.
// One access at a time; every access returns through IDLE before the next grant.
// RV32_ARB_ROUND_ROBIN_EN: when defined, ties alternate using a last_grant register;
// otherwise fixed priority with data first.
module rv32_bus_arbiter
    import rv32_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic        instr_ready_out,
    output logic [31:0] instr_read_value_out,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [31:0] data_address_in,
    input  logic [31:0] data_write_value_in,
    input  logic [3:0]  data_write_mask_in,
    output logic        data_ready_out,
    output logic [31:0] data_read_value_out,
    output logic [31:0] bus_address_out,
    output logic        bus_read_out,
    output logic        bus_write_out,
    output logic [31:0] bus_write_value_out,
    output logic [3:0]  bus_write_mask_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        bus_ready_in
);

    arb_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] wval_q, wval_d;
    logic [3:0]  mask_q, mask_d;

    logic        data_req;
    logic        grant_valid;
    arb_grant_t  grant;

    // Read+write together counts as a write.
    assign data_req = data_read_in | data_write_in;

`ifdef RV32_ARB_ROUND_ROBIN_EN
    arb_grant_t last_grant_q;

    rv32_arb_select u_select (
        .instr_req   (instr_read_in),
        .data_req    (data_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Remember the most recent winner so ties alternate.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_DATA;
        end else if (state_q == IDLE && grant_valid) begin
            last_grant_q <= grant;
        end
    end
`else
    rv32_arb_select u_select (
        .instr_req   (instr_read_in),
        .data_req    (data_req),
        .grant_valid (grant_valid),
        .grant       (grant)
    );
`endif

    // Next state and next bus register contents.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wval_d  = wval_q;
        mask_d  = mask_q;
        unique case (state_q)
            IDLE: begin
                rd_d   = 1'b0;
                wr_d   = 1'b0;
                wval_d = '0;
                mask_d = '0;
                if (grant_valid) begin
                    if (grant == GRANT_DATA) begin
                        state_d = DATA;
                        addr_d  = data_address_in;
                        rd_d    = ~data_write_in;
                        wr_d    = data_write_in;
                        wval_d  = data_write_in ? data_write_value_in : '0;
                        mask_d  = data_write_in ? data_write_mask_in : '0;
                    end else begin
                        state_d = INSTR;
                        addr_d  = instr_address_in;
                        rd_d    = 1'b1;
                    end
                end
            end
            INSTR, DATA: begin
                // Hold everything stable until memory completes, then drop to IDLE.
                if (bus_ready_in) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    wval_d  = '0;
                    mask_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and registered bus outputs; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wval_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wval_q  <= wval_d;
            mask_q  <= mask_d;
        end
    end

    // Ready is combinational from memory; suppressed while reset abandons the access.
    always_comb begin
        instr_ready_out      = bus_ready_in & ~reset & (state_q == INSTR);
        data_ready_out       = bus_ready_in & ~reset & (state_q == DATA);
        instr_read_value_out = (state_q == INSTR) ? bus_read_value_in : '0;
        data_read_value_out  = (state_q == DATA) ? bus_read_value_in : '0;
    end

    assign bus_address_out     = addr_q;
    assign bus_read_out        = rd_q;
    assign bus_write_out       = wr_q;
    assign bus_write_value_out = wval_q;
    assign bus_write_mask_out  = mask_q;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Randomized scoreboard bench for rv32_bus_arbiter.
// Requesters push each request into a per-port queue; a monitor pops at grant time and
// checks bus contents, ready pulses and read values against an ownership model.
module tb_rv32_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read_in;
    logic [31:0] instr_address_in;
    logic        instr_ready_out;
    logic [31:0] instr_read_value_out;
    logic        data_read_in;
    logic        data_write_in;
    logic [31:0] data_address_in;
    logic [31:0] data_write_value_in;
    logic [3:0]  data_write_mask_in;
    logic        data_ready_out;
    logic [31:0] data_read_value_out;
    logic [31:0] bus_address_out;
    logic        bus_read_out;
    logic        bus_write_out;
    logic [31:0] bus_write_value_out;
    logic [3:0]  bus_write_mask_out;
    logic [31:0] bus_read_value_in;
    logic        bus_ready_in;

    always #5 clk = ~clk;

    rv32_bus_arbiter dut (
        .clk                  (clk),
        .reset                (reset),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_ready_out      (instr_ready_out),
        .instr_read_value_out (instr_read_value_out),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_address_in      (data_address_in),
        .data_write_value_in  (data_write_value_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_ready_out       (data_ready_out),
        .data_read_value_out  (data_read_value_out),
        .bus_address_out      (bus_address_out),
        .bus_read_out         (bus_read_out),
        .bus_write_out        (bus_write_out),
        .bus_write_value_out  (bus_write_value_out),
        .bus_write_mask_out   (bus_write_mask_out),
        .bus_read_value_in    (bus_read_value_in),
        .bus_ready_in         (bus_ready_in)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wval;
        logic [3:0]  mask;
    } req_t;

    req_t        iq[$];
    req_t        dq[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          gen_en      = 1'b0;
    bit          i_busy      = 1'b0;
    bit          d_busy      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Fetch requester: holds each read until it sees instr_ready_out.
    initial begin
        req_t r;
        instr_read_in    = 1'b0;
        instr_address_in = '0;
        forever begin
            @(negedge clk);
            if (!i_busy) begin
                if (gen_en && $urandom_range(0, 99) < 45) begin
                    instr_read_in    = 1'b1;
                    instr_address_in = $urandom & 32'hFFFF_FFFC;
                    r.addr = instr_address_in;
                    r.wr   = 1'b0;
                    r.wval = '0;
                    r.mask = '0;
                    iq.push_back(r);
                    i_busy = 1'b1;
                end else begin
                    instr_read_in = 1'b0;
                end
            end
            #2;
            if (i_busy && instr_ready_out) i_busy = 1'b0;
        end
    end

    // Data requester: reads, writes, and read+write (treated as write).
    initial begin
        req_t r;
        int   kind;
        data_read_in        = 1'b0;
        data_write_in       = 1'b0;
        data_address_in     = '0;
        data_write_value_in = '0;
        data_write_mask_in  = '0;
        forever begin
            @(negedge clk);
            if (!d_busy) begin
                if (gen_en && $urandom_range(0, 99) < 50) begin
                    kind                = $urandom_range(0, 2);
                    data_read_in        = (kind != 1);
                    data_write_in       = (kind != 0);
                    data_address_in     = $urandom;
                    data_write_value_in = $urandom;
                    data_write_mask_in  = 4'($urandom_range(0, 15));
                    r.addr = data_address_in;
                    r.wr   = (kind != 0);
                    r.wval = data_write_value_in;
                    r.mask = data_write_mask_in;
                    dq.push_back(r);
                    d_busy = 1'b1;
                end else begin
                    data_read_in  = 1'b0;
                    data_write_in = 1'b0;
                end
            end
            #2;
            if (d_busy && data_ready_out) d_busy = 1'b0;
        end
    end

    // Memory: 0..3 wait states per access, stray ready pulses while idle.
    initial begin
        bit in_access = 1'b0;
        int wait_left = 0;
        bus_ready_in      = 1'b0;
        bus_read_value_in = '0;
        forever begin
            @(negedge clk);
            bus_read_value_in = $urandom;
            if (bus_read_out || bus_write_out) begin
                if (!in_access) begin
                    in_access = 1'b1;
                    wait_left = $urandom_range(0, 3);
                end
                if (wait_left == 0) begin
                    bus_ready_in = 1'b1;
                    in_access    = 1'b0;
                end else begin
                    wait_left--;
                    bus_ready_in = 1'b0;
                end
            end else begin
                in_access    = 1'b0;
                bus_ready_in = ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Monitor: abstract bus-ownership model, popping the scoreboard at each grant.
    initial begin
        int   owner  = 0;  // 0 none, 1 instr, 2 data
        int   g;
        bit   last_d = 1'b1;
        bit   p_ireq = 1'b0;
        bit   p_dreq = 1'b0;
        bit   p_rdy  = 1'b0;
        bit   p_rst  = 1'b1;
        bit   exp_ir, exp_dr;
        req_t cur;
        cur = '{addr: '0, wr: 1'b0, wval: '0, mask: '0};
        forever begin
            @(negedge clk);
            #1;
            if (p_rst) begin
                if (owner == 1) iq.push_front(cur);
                if (owner == 2) dq.push_front(cur);
                owner  = 0;
                last_d = 1'b1;
            end else if (owner != 0) begin
                if (p_rdy) owner = 0;
            end else if (p_ireq || p_dreq) begin
                if (p_ireq && p_dreq) begin
`ifdef RV32_ARB_ROUND_ROBIN_EN
                    g = last_d ? 1 : 2;
`else
                    g = 2;
`endif
                end else begin
                    g = p_dreq ? 2 : 1;
                end
                last_d = (g == 2);
                owner  = g;
                if ((g == 1 && iq.size() == 0) || (g == 2 && dq.size() == 0)) begin
                    miscompares++;
                    vectors++;
                    $display("FAIL scoreboard_empty: got grant %0d expected a queued request", g);
                    owner = 0;
                end else if (g == 1) begin
                    cur = iq.pop_front();
                end else begin
                    cur = dq.pop_front();
                end
            end

            if (owner == 0) begin
                check("idle_bus_read", 32'(bus_read_out), 32'd0);
                check("idle_bus_write", 32'(bus_write_out), 32'd0);
            end else begin
                check("bus_address", bus_address_out, cur.addr);
                check("bus_read", 32'(bus_read_out), 32'(!cur.wr));
                check("bus_write", 32'(bus_write_out), 32'(cur.wr));
                check("bus_mask", 32'(bus_write_mask_out), cur.wr ? 32'(cur.mask) : 32'd0);
                if (cur.wr) check("bus_wvalue", bus_write_value_out, cur.wval);
            end

            exp_ir = (owner == 1) && bus_ready_in && !reset;
            exp_dr = (owner == 2) && bus_ready_in && !reset;
            check("instr_ready", 32'(instr_ready_out), 32'(exp_ir));
            check("data_ready", 32'(data_ready_out), 32'(exp_dr));
            if (exp_ir) check("instr_rvalue", instr_read_value_out, bus_read_value_in);
            else if (owner != 1) check("instr_rvalue_ungranted", instr_read_value_out, 32'd0);
            if (exp_dr) check("data_rvalue", data_read_value_out, bus_read_value_in);
            else if (owner != 2) check("data_rvalue_ungranted", data_read_value_out, 32'd0);

            p_ireq = instr_read_in;
            p_dreq = data_read_in | data_write_in;
            p_rdy  = bus_ready_in;
            p_rst  = reset;
        end
    end

    // Main sequence: reset, quiet idle, random traffic with sporadic resets, drain.
    initial begin
        int waited;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_bus_address", bus_address_out, 32'd0);
        check("rst_bus_wvalue", bus_write_value_out, 32'd0);
        check("rst_bus_mask", 32'(bus_write_mask_out), 32'd0);
        check("rst_bus_read", 32'(bus_read_out), 32'd0);
        check("rst_bus_write", 32'(bus_write_out), 32'd0);
        repeat (10) @(negedge clk);
        gen_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        reset  = 1'b0;
        gen_en = 1'b0;
        waited = 0;
        while ((i_busy || d_busy) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (i_busy || d_busy) begin
            miscompares++;
            vectors++;
            $display("FAIL drain_timeout: got busy i=%0d d=%0d expected both idle", i_busy, d_busy);
        end
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
